// File: rtl/ram_be_if.sv
// Bus bundle for ram_be: address/control/data toward the RAM, read data and
// status back. The master side drives the request; the slave side is the RAM.
interface ram_be_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic                cs;
  logic                rd;
  logic                oe;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   read_data;
  logic                busy;
  logic                err;

  modport master (
    output addr, cs, rd, oe, be, write_data,
    input  read_data, busy, err
  );

  modport slave (
    input  addr, cs, rd, oe, be, write_data,
    output read_data, busy, err
  );
endinterface

// File: rtl/ram_be.sv
// Single-port word RAM with byte-lane write enables, 1-cycle registered read
// and an out-of-range error pulse. Define RAM_CLEAR_EN to zero-fill after reset.
module ram_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  ram_be_if.slave  bus
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              accept;
  logic              in_range;
  logic              user_we;
  logic [IDX_W-1:0]  maddr;
  logic [DATA_W-1:0] rdata_q;
  logic              valid_q;
  logic              err_q;

  assign in_range = ({1'b0, bus.addr} < DEPTH_V);
  assign maddr    = bus.addr[IDX_W-1:0];
  assign accept   = bus.cs & ~busy;
  assign user_we  = accept & ~bus.rd & in_range;

`ifdef RAM_CLEAR_EN
  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      idx    <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state  <= CLEAR;
          idx    <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // Memory has no reset; rst_n only suppresses writes so a reset aborts them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else if (user_we) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (bus.be[i]) begin
            mem[maddr][8*i +: 8] <= bus.write_data[8*i +: 8];
          end
        end
      end
    end
  end
`else
  assign busy = 1'b0;

  // Memory has no reset; rst_n only suppresses writes so a reset aborts them.
  always_ff @(posedge clk) begin
    if (rst_n && user_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (bus.be[i]) begin
          mem[maddr][8*i +: 8] <= bus.write_data[8*i +: 8];
        end
      end
    end
  end
`endif

  // Read register holds across writes; only another accepted read reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & ~in_range;
      if (accept && bus.rd) begin
        valid_q <= 1'b1;
        rdata_q <= in_range ? mem[maddr] : '0;
      end
    end
  end

  assign bus.read_data = (bus.oe && valid_q) ? rdata_q : '0;
  assign bus.busy      = busy;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ram_be.sv
// Directed bench for ram_be: a default-depth instance and a DEPTH=1000
// instance for out-of-range behaviour; follows RAM_CLEAR_EN like the design.
module tb_ram_be;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_be_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  ram_be_if #(.ADDR_W(10), .DATA_W(32)) bus_s ();

  ram_be u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ram_be #(.ADDR_W(10), .DATA_W(32), .DEPTH(1000)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

`ifdef RAM_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.write_data = d; bus.be = b;
    tick();
    bus.cs = 1'b0; bus.be = '0;
  endtask

  task automatic rd_word(input logic [9:0] a);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic wr_s(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    bus_s.cs = 1'b1; bus_s.rd = 1'b0; bus_s.addr = a; bus_s.write_data = d; bus_s.be = b;
    tick();
    bus_s.cs = 1'b0; bus_s.be = '0;
  endtask

  task automatic rd_s(input logic [9:0] a);
    bus_s.cs = 1'b1; bus_s.rd = 1'b1; bus_s.addr = a;
    tick();
    bus_s.cs = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.oe = 1'b1; bus.be = '0;
    bus.addr = '0; bus.write_data = '0;
    bus_s.cs = 1'b0; bus_s.rd = 1'b0; bus_s.oe = 1'b1; bus_s.be = '0;
    bus_s.addr = '0; bus_s.write_data = '0;
    repeat (3) tick();
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL reset_read_data: got %h want %h", bus.read_data, 32'h0);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    checks++;
    if (bus.busy !== EXP_BUSY_RST) begin
      errors++; $display("FAIL reset_busy: got %b want %b", bus.busy, EXP_BUSY_RST);
    end
    checks++;
    if (bus_s.read_data !== 32'h0) begin
      errors++; $display("FAIL reset_read_data_s: got %h want %h", bus_s.read_data, 32'h0);
    end
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    int n;
    logic saw_err;
    rst_n = 1'b1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 10'd5; bus.oe = 1'b1;
    n = 0; saw_err = 1'b0;
    while (bus.busy === 1'b1 && n < 4000) begin
      if (bus.err !== 1'b0) saw_err = 1'b1;
      n++;
      tick();
    end
    checks++;
    if (n != 1024) begin
      errors++; $display("FAIL clear_busy_cycles: got %0d want 1024", n);
    end
    checks++;
    if (saw_err !== 1'b0) begin
      errors++; $display("FAIL clear_err: got 1 want 0");
    end
    tick();
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL clear_first_read: got %h want %h", bus.read_data, 32'h0);
    end
    bus.cs = 1'b0;
  endtask

  task automatic test_mid_clear_reset();
    int n;
    wr(10'd0, 32'hDEADBEEF, 4'hF);
    wr(10'd1023, 32'hCAFEF00D, 4'hF);
    rd_word(10'd1023);
    checks++;
    if (bus.read_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL preclear_1023: got %h want %h", bus.read_data, 32'hCAFEF00D);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (500) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.read_data !== 32'h0) begin
      errors++; $display("FAIL midclear_reset_state: got busy=%b data=%h want busy=1 data=0",
                         bus.busy, bus.read_data);
    end
    rst_n = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 4000) begin
      n++;
      tick();
    end
    checks++;
    if (n != 1024) begin
      errors++; $display("FAIL restart_busy_cycles: got %0d want 1024", n);
    end
    rd_word(10'd0);
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL cleared_addr0: got %h want %h", bus.read_data, 32'h0);
    end
    rd_word(10'd1023);
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL cleared_addr1023: got %h want %h", bus.read_data, 32'h0);
    end
  endtask
`else
  task automatic test_no_clear();
    rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL noclear_busy: got %b want 0", bus.busy);
    end
    wr(10'd0, 32'h12345678, 4'hF);
    rd_word(10'd0);
    checks++;
    if (bus.read_data !== 32'h12345678) begin
      errors++; $display("FAIL noclear_read0: got %h want %h", bus.read_data, 32'h12345678);
    end
  endtask
`endif

  task automatic test_byte_enable();
    bus.oe = 1'b1;
    wr(10'd3, 32'hAABBCCDD, 4'b1111);
    wr(10'd3, 32'h11223344, 4'b0101);
    wr(10'd3, 32'hFFFFFFFF, 4'b0000);
    rd_word(10'd3);
    checks++;
    if (bus.read_data !== 32'hAA22CC44) begin
      errors++; $display("FAIL byte_enable: got %h want %h", bus.read_data, 32'hAA22CC44);
    end
  endtask

  task automatic test_oe_hold();
    bus.oe = 1'b0;
    #1;
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL oe_low: got %h want %h", bus.read_data, 32'h0);
    end
    bus.oe = 1'b1;
    #1;
    checks++;
    if (bus.read_data !== 32'hAA22CC44) begin
      errors++; $display("FAIL oe_high: got %h want %h", bus.read_data, 32'hAA22CC44);
    end
    wr(10'd3, 32'h00000000, 4'hF);
    checks++;
    if (bus.read_data !== 32'hAA22CC44) begin
      errors++; $display("FAIL hold_over_write: got %h want %h", bus.read_data, 32'hAA22CC44);
    end
    rd_word(10'd3);
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL reread_after_write: got %h want %h", bus.read_data, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h0A0A0A0A; vals[1] = 32'h0B0B0B0B;
    vals[2] = 32'h0C0C0C0C; vals[3] = 32'h0D0D0D0D;
    for (int i = 0; i < 4; i++) wr(10'(10 + i), vals[i], 4'hF);
    bus.cs = 1'b1; bus.rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = 10'(10 + i);
      tick();
      checks++;
      if (bus.read_data !== vals[i]) begin
        errors++; $display("FAIL b2b_read[%0d]: got %h want %h", i, bus.read_data, vals[i]);
      end
    end
    bus.cs = 1'b0;
    wr(10'd20, 32'h01020304, 4'hF);
    bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = 10'd20;
    bus.write_data = 32'hFF000000; bus.be = 4'b1000;
    tick();
    bus.rd = 1'b1; bus.be = '0;
    tick();
    bus.cs = 1'b0;
    checks++;
    if (bus.read_data !== 32'hFF020304) begin
      errors++; $display("FAIL read_after_write: got %h want %h", bus.read_data, 32'hFF020304);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    n = 0;
    while (bus_s.busy !== 1'b0 && n < 4000) begin
      n++;
      tick();
    end
    checks++;
    if (bus_s.busy !== 1'b0) begin
      errors++; $display("FAIL oor_ready: got busy=%b want 0", bus_s.busy);
    end
    bus_s.oe = 1'b1;
    wr_s(10'd0, 32'h00000001, 4'hF);
    wr_s(10'd999, 32'h99999999, 4'hF);
    rd_s(10'd999);
    checks++;
    if (bus_s.read_data !== 32'h99999999 || bus_s.err !== 1'b0) begin
      errors++; $display("FAIL read_last: got data=%h err=%b want data=99999999 err=0",
                         bus_s.read_data, bus_s.err);
    end
    rd_s(10'd1010);
    checks++;
    if (bus_s.err !== 1'b1 || bus_s.read_data !== 32'h0) begin
      errors++; $display("FAIL oor_read: got err=%b data=%h want err=1 data=0",
                         bus_s.err, bus_s.read_data);
    end
    tick();
    checks++;
    if (bus_s.err !== 1'b0) begin
      errors++; $display("FAIL err_single_pulse: got %b want 0", bus_s.err);
    end
    wr_s(10'd1010, 32'hFFFFFFFF, 4'hF);
    checks++;
    if (bus_s.err !== 1'b1) begin
      errors++; $display("FAIL oor_write_err: got %b want 1", bus_s.err);
    end
    tick();
    checks++;
    if (bus_s.err !== 1'b0) begin
      errors++; $display("FAIL oor_write_err_clear: got %b want 0", bus_s.err);
    end
    bus_s.cs = 1'b1; bus_s.rd = 1'b1; bus_s.addr = 10'd1000;
    tick();
    checks++;
    if (bus_s.err !== 1'b1) begin
      errors++; $display("FAIL oor_b2b_first: got %b want 1", bus_s.err);
    end
    bus_s.rd = 1'b0; bus_s.addr = 10'd1023; bus_s.write_data = 32'h5555AAAA; bus_s.be = 4'hF;
    tick();
    checks++;
    if (bus_s.err !== 1'b1) begin
      errors++; $display("FAIL oor_b2b_second: got %b want 1", bus_s.err);
    end
    bus_s.rd = 1'b1; bus_s.addr = 10'd999; bus_s.be = '0;
    tick();
    bus_s.cs = 1'b0;
    checks++;
    if (bus_s.err !== 1'b0 || bus_s.read_data !== 32'h99999999) begin
      errors++; $display("FAIL inrange_after_oor: got err=%b data=%h want err=0 data=99999999",
                         bus_s.err, bus_s.read_data);
    end
    rd_s(10'd0);
    checks++;
    if (bus_s.read_data !== 32'h00000001) begin
      errors++; $display("FAIL addr0_unchanged: got %h want %h", bus_s.read_data, 32'h00000001);
    end
  endtask

  initial begin
    test_reset();
`ifdef RAM_CLEAR_EN
    test_clear();
`else
    test_no_clear();
`endif
    test_byte_enable();
    test_oe_hold();
    test_back_to_back();
`ifdef RAM_CLEAR_EN
    test_mid_clear_reset();
`endif
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
